// File: rtl/irq_pending_latch_if.sv
// rtl/irq_pending_latch_if.sv - request/acknowledge bus between pending latch and encoder
//   req_vec   : frozen pending & ~mask snapshot (master -> slave)
//   req_valid : req_vec is valid and held stable (master -> slave)
//   req_ack   : consumer has serviced ack_idx (slave -> master)
//   ack_idx   : index being acknowledged (slave -> master)
//   ack_err   : one-cycle pulse, ack named a bit not set in req_vec (master -> slave)
interface irq_pending_latch_if #(
  parameter int N = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req_vec;
  logic          req_valid;
  logic          req_ack;
  logic [IW-1:0] ack_idx;
  logic          ack_err;

  modport master (
    output req_vec,
    output req_valid,
    output ack_err,
    input  req_ack,
    input  ack_idx
  );

  modport slave (
    input  req_vec,
    input  req_valid,
    input  ack_err,
    output req_ack,
    output ack_idx
  );
endinterface

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - edge-detecting pending latch feeding the priority encoder
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   irq_in   : raw asynchronous interrupt lines, rising-edge triggered
//   mask_we  : load mask_in into the mask register
//   mask_in  : mask value, 1 = line masked
//   bus      : request/acknowledge bus (irq_pending_latch_if.master)
//   ovf      : sticky lost-edge flags (only with IRQ_OVF_EN defined, else 0)
//   ovf_clr  : clears all ovf bits (ignored without IRQ_OVF_EN)
// Optional feature macro: IRQ_OVF_EN
module irq_pending_latch #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         irq_in,
  input  logic                 mask_we,
  input  logic [N-1:0]         mask_in,
  irq_pending_latch_if.master  bus,
  output logic [N-1:0]         ovf,
  input  logic                 ovf_clr
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_dly_q;
  logic [N-1:0] rise;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q;
  logic [N-1:0] avail;
  logic [N-1:0] req_vec_q, req_vec_d;
  logic         req_valid_q, req_valid_d;
  logic         ack_err_q, ack_err_d;
  logic [N-1:0] ack_onehot;
  logic         ack_hit;
  logic [N-1:0] clr;

  // Synchronizer chain plus one delay flop for edge detection. Because the
  // delay flop resets to 0, a line already high at reset release is seen as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      sync_dly_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  assign avail = pending_q & ~mask_q;

  // Out-of-range ack_idx values decode to an all-zero one-hot, so they can
  // never hit req_vec and naturally fall into the ack_err path.
  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < N; i++) begin
      ack_onehot[i] = (bus.ack_idx == IW'(i));
    end
  end

  assign ack_hit = |(ack_onehot & req_vec_q);

  always_comb begin
    state_d     = state_q;
    req_vec_d   = req_vec_q;
    req_valid_d = req_valid_q;
    ack_err_d   = 1'b0;
    clr         = '0;
    case (state_q)
      IDLE: begin
        // req_ack is deliberately ignored here.
        if (|avail) begin
          state_d     = PRESENT;
          req_vec_d   = avail;
          req_valid_d = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.req_ack) begin
          if (ack_hit) begin
            clr = ack_onehot;
          end else begin
            ack_err_d = 1'b1;
          end
          state_d     = IDLE;
          req_vec_d   = '0;
          req_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_vec_d   = '0;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // A new edge on the bit being cleared wins: it is ORed in after the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      req_vec_q   <= '0;
      req_valid_q <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_vec_q   <= req_vec_d;
      req_valid_q <= req_valid_d;
      ack_err_q   <= ack_err_d;
      if (mask_we) begin
        mask_q <= mask_in;
      end
    end
  end

  assign bus.req_vec   = req_vec_q;
  assign bus.req_valid = req_valid_q;
  assign bus.ack_err   = ack_err_q;

`ifdef IRQ_OVF_EN
  logic [N-1:0] ovf_q;

  // An edge is lost when the bit is already pending and is not being
  // cleared this cycle. A fresh overflow beats ovf_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - scoreboard bench for irq_pending_latch
module tb_irq_pending_latch;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] vec;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_in;
  logic [N-1:0] ovf;
  logic         ovf_clr;

  int   cyc;
  int   checks;
  int   errors;
  logic prev_valid;
  exp_t exp_q[$];
  int   err_q[$];

  irq_pending_latch_if #(.N(N)) bus ();

  irq_pending_latch #(.N(N), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .bus     (bus),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every new presentation and every ack_err pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {24'd0, bus.req_vec}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("req_vec", {24'd0, bus.req_vec}, {24'd0, e.vec});
          chk("req_cycle", cyc, e.cyc);
        end
      end
      if (bus.ack_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_ack_err", 32'd1, 32'd0);
        end else begin
          chk("ack_err_cycle", cyc, err_q.pop_front());
        end
      end
      prev_valid = bus.req_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [N-1:0] v, input int c);
    exp_t e;
    e.vec = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.req_valid && n < 60) begin
      tick(1);
      n++;
    end
    if (!bus.req_valid) chk(name, 32'd0, 32'd1);
  endtask

  // Raises one line for two cycles; c returns the cycle in which it went high.
  task automatic pulse(input int b, output int c);
    c = cyc;
    irq_in[b] = 1'b1;
    tick(2);
    irq_in[b] = 1'b0;
  endtask

  task automatic do_ack(input int idx);
    bus.req_ack = 1'b1;
    bus.ack_idx = 3'(idx);
    tick(1);
    bus.req_ack = 1'b0;
    bus.ack_idx = '0;
  endtask

  initial begin
    int c;
    logic [N-1:0] rem;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    prev_valid  = 1'b0;
    rst_n       = 1'b0;
    irq_in      = 8'hFF;
    mask_we     = 1'b0;
    mask_in     = '0;
    ovf_clr     = 1'b0;
    bus.req_ack = 1'b0;
    bus.ack_idx = '0;

    // Reset with all lines high: outputs 0, request at the fourth edge after release.
    tick(3);
    chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
    chk("rst_req_vec", {24'd0, bus.req_vec}, 32'd0);
    chk("rst_ack_err", {31'd0, bus.ack_err}, 32'd0);
    chk("rst_ovf", {24'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    push_req(8'hFF, cyc + 4);
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      chk("post_rst_idle", {31'd0, bus.req_valid}, 32'd0);
    end
    // Drain all eight bits, lowest first; each ack re-presents the remainder.
    rem = 8'hFF;
    for (int k = 0; k < N; k++) begin
      wait_valid("timeout_drain");
      rem[k] = 1'b0;
      if (rem != 0) push_req(rem, cyc + 2);
      do_ack(k);
      chk("drain_valid_drop", {31'd0, bus.req_valid}, 32'd0);
    end
    irq_in = '0;
    tick(6);
    chk("drain_empty", {31'd0, bus.req_valid}, 32'd0);

    // Ack while IDLE is ignored.
    do_ack(0);
    tick(2);
    chk("idle_ack_no_err", {31'd0, bus.ack_err}, 32'd0);

    // Single interrupt on line 5.
    c = cyc;
    push_req(8'h20, c + 4);
    pulse(5, c);
    wait_valid("timeout_single");
    do_ack(5);
    chk("single_valid_drop", {31'd0, bus.req_valid}, 32'd0);
    tick(6);
    chk("single_pending_empty", {31'd0, bus.req_valid}, 32'd0);

    // Masked line latches but is not presented until unmasked.
    mask_we = 1'b1;
    mask_in = 8'h04;
    tick(1);
    mask_we = 1'b0;
    pulse(2, c);
    tick(8);
    chk("masked_no_valid", {31'd0, bus.req_valid}, 32'd0);
    push_req(8'h04, cyc + 2);
    mask_we = 1'b1;
    mask_in = 8'h00;
    tick(1);
    mask_we = 1'b0;
    wait_valid("timeout_unmask");
    do_ack(2);
    tick(4);

    // Freeze while presenting, then requeue the later edge.
    push_req(8'h01, cyc + 4);
    pulse(0, c);
    wait_valid("timeout_freeze");
    pulse(7, c);
    tick(6);
    chk("freeze_vec", {24'd0, bus.req_vec}, 32'h01);
    chk("freeze_valid", {31'd0, bus.req_valid}, 32'd1);
    push_req(8'h80, cyc + 2);
    do_ack(0);
    chk("requeue_idle_gap", {31'd0, bus.req_valid}, 32'd0);
    wait_valid("timeout_requeue");
    do_ack(7);
    tick(4);

    // Ack of a bit not presented: error pulse, bit kept and re-presented.
    push_req(8'h02, cyc + 4);
    pulse(1, c);
    wait_valid("timeout_badack");
    err_q.push_back(cyc + 1);
    push_req(8'h02, cyc + 2);
    do_ack(3);
    chk("badack_valid_drop", {31'd0, bus.req_valid}, 32'd0);
    wait_valid("timeout_represent");
    do_ack(1);
    tick(4);

    // Second edge on a pending line.
    push_req(8'h10, cyc + 4);
    pulse(4, c);
    wait_valid("timeout_ovf");
    tick(1);
    pulse(4, c);
    tick(5);
`ifdef IRQ_OVF_EN
    chk("ovf_set", {24'd0, ovf}, 32'h10);
`else
    chk("ovf_tied", {24'd0, ovf}, 32'h00);
`endif
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {24'd0, ovf}, 32'h00);
    do_ack(4);
    tick(6);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("err_q_empty", err_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
